// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the program counter, the decode-mode
// and compare-flag registers, and the IDLE/RUN/HALT run control.
module fetch_seq (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [8:0]  StartAddr,
    input  logic [8:0]  InstrIn,
    input  logic        BranchEn,
    input  logic [8:0]  BranchTarget,
    input  logic [1:0]  NextState,
    input  logic [8:0]  PrevInstructionIn,
    input  logic        CMPLoadEn,
    input  logic [2:0]  CMPBitsIn,
    input  logic        Ack,
    output logic [8:0]  ProgCtr,
    output logic [8:0]  Instruction,
    output logic [8:0]  PrevInstruction,
    output logic [1:0]  CurrState,
    output logic [2:0]  CMPBits,
    output logic        Running,
    output logic        Done,
    output logic [15:0] CycleCnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0] state;

    // Run control and all architectural registers; Start wins over
    // everything, the unused encoding simply holds.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            ProgCtr         <= 9'd0;
            CurrState       <= 2'b00;
            PrevInstruction <= 9'd0;
            CMPBits         <= 3'b000;
            CycleCnt        <= 16'd0;
        end else if (Start) begin
            state           <= RUN;
            ProgCtr         <= StartAddr;
            CurrState       <= 2'b00;
            PrevInstruction <= 9'd0;
            CMPBits         <= 3'b000;
            CycleCnt        <= 16'd0;
        end else if (state == RUN) begin
            if (CMPLoadEn)
                CMPBits <= CMPBitsIn;
            if (CycleCnt != 16'hFFFF)
                CycleCnt <= CycleCnt + 16'd1;
            if (Ack) begin
                state <= HALT;
            end else begin
                ProgCtr         <= BranchEn ? BranchTarget
                                            : ProgCtr + 9'd1;
                CurrState       <= NextState;
                PrevInstruction <= PrevInstructionIn;
            end
        end
    end

    // Status decode and NOP gating so the decoder is inert when stopped.
    always_comb begin
        Running     = (state == RUN);
        Done        = (state == HALT);
        Instruction = Running ? InstrIn : 9'h000;
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: a behavioural model pushes the
// expected post-edge outputs, which are popped and compared.
module tb_fetch_seq;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [8:0]  StartAddr = '0;
    logic [8:0]  InstrIn;
    logic        BranchEn = 1'b0;
    logic [8:0]  BranchTarget = '0;
    logic [1:0]  NextState = '0;
    logic [8:0]  PrevInstructionIn = '0;
    logic        CMPLoadEn = 1'b0;
    logic [2:0]  CMPBitsIn = '0;
    logic        Ack = 1'b0;
    logic [8:0]  ProgCtr;
    logic [8:0]  Instruction;
    logic [8:0]  PrevInstruction;
    logic [1:0]  CurrState;
    logic [2:0]  CMPBits;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCnt;

    fetch_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .StartAddr(StartAddr), .InstrIn(InstrIn),
        .BranchEn(BranchEn), .BranchTarget(BranchTarget),
        .NextState(NextState),
        .PrevInstructionIn(PrevInstructionIn),
        .CMPLoadEn(CMPLoadEn), .CMPBitsIn(CMPBitsIn),
        .Ack(Ack), .ProgCtr(ProgCtr),
        .Instruction(Instruction),
        .PrevInstruction(PrevInstruction),
        .CurrState(CurrState), .CMPBits(CMPBits),
        .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    // instruction ROM: a simple scramble of the address
    function automatic logic [8:0] rom(input logic [8:0] a);
        return a ^ 9'h0B5;
    endfunction
    assign InstrIn = rom(ProgCtr);

    typedef struct packed {
        logic [8:0]  pc;
        logic [8:0]  ins;
        logic [8:0]  prev;
        logic [1:0]  cs;
        logic [2:0]  cmp;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // model state: 0 idle, 1 run, 2 halt
    int          m_st;
    logic [8:0]  m_pc;
    logic [8:0]  m_prev;
    logic [1:0]  m_cs;
    logic [2:0]  m_cmp;
    logic [15:0] m_cnt;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 0; m_prev = 0;
        m_cs = 0; m_cmp = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else if (Start) begin
            m_st = 1; m_pc = StartAddr; m_prev = 0;
            m_cs = 0; m_cmp = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            if (CMPLoadEn) m_cmp = CMPBitsIn;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (Ack) begin
                m_st = 2;
            end else begin
                if (BranchEn) m_pc = BranchTarget;
                else m_pc = (m_pc == 9'd511) ? 9'd0 : m_pc + 9'd1;
                m_cs = NextState;
                m_prev = PrevInstructionIn;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc;
        e.prev = m_prev;
        e.cs = m_cs;
        e.cmp = m_cmp;
        e.run = (m_st == 1);
        e.done = (m_st == 2);
        e.ins = (m_st == 1) ? rom(m_pc) : 9'h000;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_pc"}, 32'(ProgCtr), 32'(e.pc));
        check({tag, "_ins"}, 32'(Instruction), 32'(e.ins));
        check({tag, "_prev"}, 32'(PrevInstruction), 32'(e.prev));
        check({tag, "_cs"}, 32'(CurrState), 32'(e.cs));
        check({tag, "_cmp"}, 32'(CMPBits), 32'(e.cmp));
        check({tag, "_run"}, 32'(Running), 32'(e.run));
        check({tag, "_done"}, 32'(Done), 32'(e.done));
        check({tag, "_cnt"}, 32'(CycleCnt), 32'(e.cnt));
    endtask

    task automatic drive(input logic st, input logic [8:0] sa,
                         input logic br, input logic [8:0] bt,
                         input logic [1:0] ns, input logic [8:0] pin,
                         input logic cl, input logic [2:0] cb,
                         input logic ak);
        Start = st; StartAddr = sa; BranchEn = br;
        BranchTarget = bt; NextState = ns;
        PrevInstructionIn = pin; CMPLoadEn = cl;
        CMPBitsIn = cb; Ack = ak;
    endtask

    task automatic step(input string tag);
        model_edge();
        push_exp();
        @(posedge Clk);
        #1;
        compare(tag);
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        idle_in();
        #2;
        push_exp();
        compare("reset");
        @(negedge Clk);
        drive(1, 9'd5, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        step("start5");
        check("pc_start", 32'(ProgCtr), 32'd5);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 9'(i + 7), 0, 0, 0);
            step("seq");
        end
        check("pc_after4", 32'(ProgCtr), 32'd9);
        check("cnt_after4", 32'(CycleCnt), 32'd4);
        drive(0, 0, 0, 0, 2'b10, 9'h011, 1, 3'b011, 0);
        step("cmp_load");
        drive(0, 0, 0, 0, 0, 9'h022, 0, 3'b100, 0);
        step("cmp_hold");
        check("cmp_held", 32'(CMPBits), 32'h3);
        drive(0, 0, 1, 9'h0A3, 2'b01, 9'h033, 0, 0, 0);
        step("branch");
        check("br_pc", 32'(ProgCtr), 32'h0A3);
        check("br_cs", 32'(CurrState), 32'h1);
        drive(0, 0, 1, 9'h1FF, 2'b11, 9'h044, 0, 0, 0);
        step("br511");
        drive(0, 0, 0, 0, 2'b11, 9'h055, 0, 0, 0);
        step("wrap");
        check("wrap_pc", 32'(ProgCtr), 32'h0);
        check("cs_11", 32'(CurrState), 32'h3);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1'($urandom_range(0, 1)),
                  9'($urandom), 2'($urandom),
                  9'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom), 0);
            step("rand");
        end
        drive(0, 0, 1, 9'h100, 2'b01, 9'h066, 0, 0, 1);
        step("ack");
        check("ack_done", 32'(Done), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 9'h111, 2'b10, 9'h077, 1, 3'b111, 0);
            step("halt_hold");
        end
        check("halt_nop", 32'(Instruction), 32'h0);
        drive(1, 9'd30, 0, 0, 0, 0, 0, 0, 0);
        step("start30");
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 2'b01, 9'(i), 1, 3'(i), 0);
            step("to40");
        end
        check("pc40", 32'(ProgCtr), 32'd40);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        push_exp();
        compare("async_rst");
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle_in();
        for (int i = 0; i < 3; i++) step("post_rst_idle");
        check("no_resume", 32'(Running), 32'h0);
        drive(1, 9'd200, 0, 0, 0, 0, 0, 0, 0);
        step("restart");
        check("restart_pc", 32'(ProgCtr), 32'd200);
        idle_in();
        for (int i = 0; i < 65540; i++) begin
            model_edge();
            @(posedge Clk);
        end
        #1;
        push_exp();
        compare("saturate");
        check("cnt_sat", 32'(CycleCnt), 32'hFFFF);
        step("sat_hold");
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; asserting low immediately forces every register to its reset value.
REQ-003 Start  input  1  level-sampled request to begin execution at StartAddr.
REQ-004 StartAddr  input  9  first program-counter value loaded on Start.
REQ-005 InstrIn  input  9  instruction word read combinationally from instruction ROM at ProgCtr.
REQ-006 BranchEn  input  1  from control decoder; take branch this cycle.
REQ-007 BranchTarget  input  9  from control decoder; next PC when BranchEn=1.
REQ-008 NextState  input  2  from control decoder; decode mode for next instruction (00 regular, 01 target, 10 immediate, 11 unused).
REQ-009 PrevInstructionIn  input  9  from control decoder; instruction word to retain for the next cycle.
REQ-010 CMPLoadEn  input  1  from control decoder; capture CMPBitsIn.
REQ-011 CMPBitsIn  input  3  compare flags {zero, equal, GT}.
REQ-012 Ack  input  1  from control decoder; program finished.
REQ-013 ProgCtr  output  9  current instruction address to ROM.
REQ-014 Instruction  output  9  instruction presented to control decoder.
REQ-015 PrevInstruction  output  9  registered copy of PrevInstructionIn.
REQ-016 CurrState  output  2  registered decode mode.
REQ-017 CMPBits  output  3  registered compare flags.
REQ-018 Running  output  1  high while in RUN.
REQ-019 Done  output  1  high while in HALT.
REQ-020 CycleCnt  output  16  RUN cycles elapsed since last Start.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, HALT; reset state IDLE.
REQ-022 In any state, Start=1 SHALL on the next edge load ProgCtr=StartAddr, CurrState=00, PrevInstruction=0, CMPBits=0, CycleCnt=0, and enter RUN (Start has highest priority).
REQ-023 IDLE/HALT without Start: all registers hold.
REQ-024 Instruction SHALL equal InstrIn in RUN and 9'h000 (NOP) in IDLE and HALT, so decoder outputs are inert.
REQ-025 RUN, Ack=1: enter HALT next edge; ProgCtr, CurrState, PrevInstruction hold; Ack overrides BranchEn.
REQ-026 RUN, Ack=0, BranchEn=1: ProgCtr <= BranchTarget.
REQ-027 RUN, Ack=0, BranchEn=0: ProgCtr <= ProgCtr+1, modulo 512 (511 wraps to 0).
REQ-028 RUN, Ack=0: CurrState <= NextState, PrevInstruction <= PrevInstructionIn every cycle.
REQ-029 RUN, CMPLoadEn=1: CMPBits <= CMPBitsIn; otherwise hold; CMPLoadEn ignored outside RUN.
REQ-030 CycleCnt SHALL increment by 1 on each RUN edge (including the Ack edge), saturating at 16'hFFFF.
REQ-031 Running=(state==RUN), Done=(state==HALT), both decoded combinationally from the state register.
REQ-032 NextState=11 SHALL be stored unchanged; no recovery action.
REQ-033 Latency: a BranchEn seen in cycle N SHALL make ProgCtr=BranchTarget in cycle N+1; no delay slots.

Reset
REQ-034 Reset low SHALL asynchronously set state=IDLE, ProgCtr=0, CurrState=00, PrevInstruction=0, CMPBits=0, CycleCnt=0, hence Instruction=0, Running=0, Done=0.
REQ-035 Reset asserted mid-RUN SHALL abort without completing any pending update; release requires Start to resume.
REQ-036 Start high during reset release edge SHALL be honoured on the first edge after Reset goes high.

Verification
REQ-037 Reset then Start=1 StartAddr=9'd5, no branches, 4 cycles -> ProgCtr 5,6,7,8,9; Running=1; CycleCnt=4.
REQ-038 ProgCtr=511, BranchEn=0 -> next ProgCtr=0; wrap without stall.
REQ-039 RUN, BranchEn=1 BranchTarget=9'h0A3 with NextState=01 -> next cycle ProgCtr=0A3, CurrState=01.
REQ-040 RUN, Ack=1 and BranchEn=1 same cycle -> HALT, Done=1, ProgCtr unchanged, Instruction=000 thereafter.
REQ-041 CMPLoadEn=1 CMPBitsIn=3'b011, then CMPLoadEn=0 CMPBitsIn=3'b100 -> CMPBits=011 and holds.
REQ-042 Reset pulled low mid-RUN at ProgCtr=40 -> all outputs to reset values immediately; Start required to restart at StartAddr.
